// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for a single-port RAM, with a built-in
// engine that fills every word with a programmable value.
module ram_arbiter #(
   parameter  int DATA_WIDTH = 32,
   parameter  int WORDS      = 128,
   localparam int ADDR_WIDTH = $clog2(WORDS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rq0_valid,
   input  logic                  rq0_we,
   input  logic [ADDR_WIDTH-1:0] rq0_addr,
   input  logic [DATA_WIDTH-1:0] rq0_wdata,
   output logic                  rq0_ready,
   input  logic                  rq1_valid,
   input  logic                  rq1_we,
   input  logic [ADDR_WIDTH-1:0] rq1_addr,
   input  logic [DATA_WIDTH-1:0] rq1_wdata,
   output logic                  rq1_ready,
   output logic                  rs0_valid,
   output logic [DATA_WIDTH-1:0] rs0_rdata,
   output logic                  rs1_valid,
   output logic [DATA_WIDTH-1:0] rs1_rdata,
   input  logic                  fill_start,
   input  logic [DATA_WIDTH-1:0] fill_value,
   output logic                  fill_busy,
   output logic                  fill_done,
   output logic                  ram_wrenable,
   output logic                  ram_rdenable,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  dbg_state
);

   // Handshake: a request transfers on the rising edge where valid & ready
   // are both high; ready is combinational and never depends on itself.
   typedef enum logic {ST_ARB = 1'b0, ST_FILL = 1'b1} state_t;

   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(WORDS - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH:0]   fill_cnt;
   logic [DATA_WIDTH-1:0] fill_data;
   logic                  last_grant;
   logic                  grant0, grant1;
   logic                  fill_last;

   assign fill_last = (fill_cnt == LAST_ADDR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_ARB;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ARB:  if (fill_start) state_nxt = ST_FILL;
         ST_FILL: if (fill_last)  state_nxt = ST_ARB;
         default: state_nxt = ST_ARB;
      endcase
   end

   // Grants are gated by reset so every output reads 0 while it is held.
   always_comb begin
      grant0       = 1'b0;
      grant1       = 1'b0;
      ram_wrenable = 1'b0;
      ram_rdenable = 1'b0;
      ram_address  = '0;
      ram_data_in  = '0;
      if (reset) begin
         case (state)
            ST_ARB: begin
               grant0 = rq0_valid && (!rq1_valid || last_grant);
               grant1 = rq1_valid && !grant0;
               if (grant0) begin
                  ram_wrenable = rq0_we;
                  ram_rdenable = !rq0_we;
                  ram_address  = rq0_addr;
                  ram_data_in  = rq0_wdata;
               end else if (grant1) begin
                  ram_wrenable = rq1_we;
                  ram_rdenable = !rq1_we;
                  ram_address  = rq1_addr;
                  ram_data_in  = rq1_wdata;
               end
            end
            ST_FILL: begin
               ram_wrenable = 1'b1;
               ram_address  = fill_cnt[ADDR_WIDTH-1:0];
               ram_data_in  = fill_data;
            end
            default: ;
         endcase
      end
   end

   assign rq0_ready = grant0;
   assign rq1_ready = grant1;
   assign fill_busy = (state == ST_FILL);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
         fill_cnt   <= '0;
         fill_data  <= '0;
         fill_done  <= 1'b0;
         rs0_valid  <= 1'b0;
         rs0_rdata  <= '0;
         rs1_valid  <= 1'b0;
         rs1_rdata  <= '0;
      end else begin
         rs0_valid <= grant0 && !rq0_we;
         rs1_valid <= grant1 && !rq1_we;
         if (grant0 && !rq0_we) rs0_rdata <= ram_data_out;
         if (grant1 && !rq1_we) rs1_rdata <= ram_data_out;
         if (grant0)      last_grant <= 1'b0;
         else if (grant1) last_grant <= 1'b1;
         fill_done <= (state == ST_FILL) && fill_last;
         if (state == ST_ARB && fill_start) begin
            fill_data <= fill_value;
            fill_cnt  <= '0;
         end else if (state == ST_FILL) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        rq0_valid, rq0_we, rq1_valid, rq1_we;
   logic [6:0]  rq0_addr, rq1_addr;
   logic [31:0] rq0_wdata, rq1_wdata;
   logic        rq0_ready, rq1_ready, rs0_valid, rs1_valid;
   logic [31:0] rs0_rdata, rs1_rdata;
   logic        fill_start, fill_busy, fill_done;
   logic [31:0] fill_value;
   logic        ram_wrenable, ram_rdenable;
   logic [6:0]  ram_address;
   logic [31:0] ram_data_in, ram_data_out;
   logic        dbg_state;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [128];

   always #5 clk = ~clk;

   ram_arbiter #(.DATA_WIDTH(32), .WORDS(128)) dut (
      .clk(clk), .reset(reset),
      .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
      .rq0_ready(rq0_ready),
      .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
      .rq1_ready(rq1_ready),
      .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata),
      .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata),
      .fill_start(fill_start), .fill_value(fill_value),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .ram_wrenable(ram_wrenable), .ram_rdenable(ram_rdenable),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out), .dbg_state(dbg_state)
   );

   initial for (int i = 0; i < 128; i++) mem[i] = 32'h0;
   always @(posedge clk) if (ram_wrenable) mem[ram_address] <= ram_data_in;
   assign ram_data_out = mem[ram_address];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read0(input logic [6:0] addr, input logic [31:0] exp, input string tag);
      step();
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = addr;
      @(negedge clk);
      check({tag, "_ready"}, 32'(rq0_ready), 32'd1);
      step();
      rq0_valid = 1'b0;
      @(negedge clk);
      check({tag, "_rsv"}, 32'(rs0_valid), 32'd1);
      check({tag, "_data"}, rs0_rdata, exp);
   endtask

   initial begin
      int done_cnt;
      int busy_cnt;
      reset = 1'b0;
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
      rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
      fill_start = 1'b0; fill_value = '0;

      // Reset state, with both valids high to prove ready is held low
      repeat (2) @(negedge clk);
      check("rst_rdy0", 32'(rq0_ready), 32'd0);
      check("rst_rdy1", 32'(rq1_ready), 32'd0);
      check("rst_rsv0", 32'(rs0_valid), 32'd0);
      check("rst_rsd0", rs0_rdata, 32'h0);
      check("rst_busy", 32'(fill_busy), 32'd0);
      check("rst_done", 32'(fill_done), 32'd0);
      check("rst_we",   32'(ram_wrenable), 32'd0);
      check("rst_re",   32'(ram_rdenable), 32'd0);
      check("rst_addr", 32'(ram_address), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      step();
      reset = 1'b1; rq0_valid = 1'b0; rq1_valid = 1'b0;

      // Single port: write then read-after-write on rq0
      step();
      rq0_valid = 1'b1; rq0_we = 1'b1; rq0_addr = 7'd5; rq0_wdata = 32'hDEADBEEF;
      @(negedge clk);
      check("wr_ready", 32'(rq0_ready), 32'd1);
      check("wr_we",    32'(ram_wrenable), 32'd1);
      check("wr_addr",  32'(ram_address), 32'd5);
      check("wr_data",  ram_data_in, 32'hDEADBEEF);
      step();
      rq0_we = 1'b0;
      @(negedge clk);
      check("rd_ready", 32'(rq0_ready), 32'd1);
      check("rd_re",    32'(ram_rdenable), 32'd1);
      check("wr_norsp", 32'(rs0_valid), 32'd0);
      step();
      rq0_valid = 1'b0;
      @(negedge clk);
      check("rd_rsv0", 32'(rs0_valid), 32'd1);
      check("rd_data", rs0_rdata, 32'hDEADBEEF);
      check("rd_rsv1", 32'(rs1_valid), 32'd0);
      step();
      @(negedge clk);
      check("rd_pulse", 32'(rs0_valid), 32'd0);
      check("rd_hold", rs0_rdata, 32'hDEADBEEF);

      // rq1 write alone, then full contention on reads
      step();
      rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = 7'd7; rq1_wdata = 32'h12345678;
      @(negedge clk);
      check("w1_ready", 32'(rq1_ready), 32'd1);
      check("w1_rdy0",  32'(rq0_ready), 32'd0);
      step();
      rq1_we = 1'b0;
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 7'd5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("ct_rdy0", 32'(rq0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         check("ct_rdy1", 32'(rq1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
         check("ct_addr", 32'(ram_address), (i % 2 == 0) ? 32'd5 : 32'd7);
         check("ct_rsv0", 32'(rs0_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
         check("ct_rsv1", 32'(rs1_valid), (i > 0 && i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 1) check("ct_rsd0", rs0_rdata, 32'hDEADBEEF);
         if (i > 0 && i % 2 == 0) check("ct_rsd1", rs1_rdata, 32'h12345678);
         step();
      end
      rq0_valid = 1'b0; rq1_valid = 1'b0;
      @(negedge clk);
      check("ct_last1", 32'(rs1_valid), 32'd1);
      check("ct_lastd", rs1_rdata, 32'h12345678);
      check("ct_last0", 32'(rs0_valid), 32'd0);

      // Fill after a reset pulse
      step();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      fill_start = 1'b1; fill_value = 32'hA5A5A5A5;
      @(negedge clk);
      check("f_busy0", 32'(fill_busy), 32'd0);
      step();
      fill_start = 1'b0; fill_value = 32'hFFFFFFFF;
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         check("f_busy", 32'(fill_busy), 32'd1);
         check("f_addr", 32'(ram_address), 32'(k));
         check("f_data", ram_data_in, 32'hA5A5A5A5);
         check("f_done_lo", 32'(fill_done), 32'd0);
         step();
      end
      @(negedge clk);
      check("f_busy_end", 32'(fill_busy), 32'd0);
      check("f_done", 32'(fill_done), 32'd1);
      check("f_state", 32'(dbg_state), 32'd0);
      step();
      @(negedge clk);
      check("f_done_pulse", 32'(fill_done), 32'd0);
      read0(7'd0,   32'hA5A5A5A5, "f_rd0");
      read0(7'd64,  32'hA5A5A5A5, "f_rd64");
      read0(7'd127, 32'hA5A5A5A5, "f_rd127");

      // Fill blocking rq1, with a second fill_start mid-fill
      step();
      fill_start = 1'b1; fill_value = 32'h0F0F0F0F;
      @(negedge clk);
      step();
      fill_start = 1'b0;
      rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 7'd3;
      for (int k = 0; k < 128; k++) begin
         @(negedge clk);
         check("b_rdy1", 32'(rq1_ready), 32'd0);
         check("b_addr", 32'(ram_address), 32'(k));
         step();
         if (k == 49) fill_start = 1'b1;
         if (k == 50) fill_start = 1'b0;
      end
      @(negedge clk);
      check("b_busy_end", 32'(fill_busy), 32'd0);
      check("b_done", 32'(fill_done), 32'd1);
      check("b_rdy1_up", 32'(rq1_ready), 32'd1);
      step();
      rq1_valid = 1'b0;
      @(negedge clk);
      check("b_rsv1", 32'(rs1_valid), 32'd1);
      check("b_rsd1", rs1_rdata, 32'h0F0F0F0F);

      // Reset at fill counter 40 with both requesters waiting
      step();
      fill_start = 1'b1; fill_value = 32'h55555555;
      @(negedge clk);
      step();
      fill_start = 1'b0;
      rq0_valid = 1'b1; rq0_addr = 7'd5; rq1_valid = 1'b1; rq1_addr = 7'd7;
      for (int k = 0; k < 40; k++) step();
      @(negedge clk);
      check("m_addr40", 32'(ram_address), 32'd40);
      #1 reset = 1'b0;
      #1;
      check("m_busy", 32'(fill_busy), 32'd0);
      check("m_we",   32'(ram_wrenable), 32'd0);
      check("m_addr", 32'(ram_address), 32'd0);
      check("m_data", ram_data_in, 32'h0);
      check("m_rdy0", 32'(rq0_ready), 32'd0);
      check("m_rdy1", 32'(rq1_ready), 32'd0);
      check("m_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("m_tie0", 32'(rq0_ready), 32'd1);
      check("m_tie1", 32'(rq1_ready), 32'd0);
      step();
      rq0_valid = 1'b0; rq1_valid = 1'b0;
      done_cnt = 0;
      busy_cnt = 0;
      for (int k = 0; k < 140; k++) begin
         @(negedge clk);
         if (fill_done) done_cnt++;
         if (fill_busy) busy_cnt++;
         step();
      end
      check("m_no_done", 32'(done_cnt), 32'd0);
      check("m_no_busy", 32'(busy_cnt), 32'd0);

      // Read transfer in the same cycle as fill_start
      step();
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 7'd64;
      fill_start = 1'b1; fill_value = 32'h3C3C3C3C;
      @(negedge clk);
      check("s_rdy0", 32'(rq0_ready), 32'd1);
      step();
      rq0_valid = 1'b0; fill_start = 1'b0;
      @(negedge clk);
      check("s_busy", 32'(fill_busy), 32'd1);
      check("s_rsv0", 32'(rs0_valid), 32'd1);
      check("s_rsd0", rs0_rdata, 32'h0F0F0F0F);
      check("s_addr0", 32'(ram_address), 32'd0);
      repeat (128) step();
      @(negedge clk);
      check("s_done", 32'(fill_done), 32'd1);
      read0(7'd40, 32'h3C3C3C3C, "s_rd40");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
